// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port indices and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int          WDOG_W      = 8;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  // Data returned to the owner on completion: poison on abort, zero on writes.
  function automatic logic [31:0] ack_data(input logic        abort,
                                           input logic        we,
                                           input logic [31:0] mem_dout);
    logic [31:0] d;
    d = mem_dout;
    if (abort) begin
      d = ERR_DATA;
    end else if (we) begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: two requester ports plus the shared memory port.
// master = arbiter side, slave = requesters and memory.
interface mem_arbiter_if;

  logic        p0_cs,    p1_cs;
  logic        p0_we,    p1_we;
  logic [31:0] p0_addr,  p1_addr;
  logic [31:0] p0_din,   p1_din;
  logic [31:0] p0_dout,  p1_dout;
  logic        p0_ack,   p1_ack;
  logic        p0_stall, p1_stall;
  logic        p0_err,   p1_err;

  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  modport master (
    input  p0_cs, p0_we, p0_addr, p0_din,
    input  p1_cs, p1_we, p1_addr, p1_din,
    output p0_dout, p0_ack, p0_stall, p0_err,
    output p1_dout, p1_ack, p1_stall, p1_err,
    output mem_cs, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    output p0_cs, p0_we, p0_addr, p0_din,
    output p1_cs, p1_we, p1_addr, p1_din,
    input  p0_dout, p0_ack, p0_stall, p0_err,
    input  p1_dout, p1_ack, p1_stall, p1_err,
    input  mem_cs, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way winner select, purely combinational; round-robin or port-0 priority.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  input  logic       i_rr_en,
  output logic       o_grant,
  output logic       o_grant_vld
);

  always_comb begin
    o_grant_vld = |i_req;
    o_grant     = PORT0;
    case (i_req)
      2'b10:   o_grant = PORT1;
      // Contention: hand the bus to whoever was not served last.
      2'b11:   o_grant = (i_rr_en && (i_last_owner == PORT0)) ? PORT1 : PORT0;
      default: o_grant = PORT0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: request at T, mem_cs at T+1, ack in the mem_ack cycle (T+2 min).
// Losing/waiting ports stall until their own ack; a watchdog aborts a hung memory access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.master io_bus
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  logic              r_mem_cs;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_din;
  logic [WDOG_W-1:0] r_wdog;

  logic        w_grant;
  logic        w_grant_vld;
  logic        w_busy;
  logic        w_expire;
  logic        w_done;
  logic        w_abort;
  logic [31:0] w_ack_dat;

  arb_rr2 u_arb (
    .i_req        ({io_bus.p1_cs, io_bus.p0_cs}),
    .i_last_owner (r_last_owner),
    .i_rr_en      (RR_EN),
    .o_grant      (w_grant),
    .o_grant_vld  (w_grant_vld)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_expire  = w_busy && (r_wdog == WDOG_LAST);
  assign w_done    = w_busy && (io_bus.mem_ack || w_expire);
  // A real ack in the expiry cycle wins over the abort.
  assign w_abort   = w_expire && !io_bus.mem_ack;
  assign w_ack_dat = ack_data(w_abort, r_we, io_bus.mem_dout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_mem_cs     <= 1'b0;
      r_owner      <= PORT0;
      r_last_owner <= PORT1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (w_grant_vld) begin
            r_state  <= ST_BUSY;
            r_mem_cs <= 1'b1;
            r_owner  <= w_grant;
            r_we     <= (w_grant == PORT1) ? io_bus.p1_we   : io_bus.p0_we;
            r_addr   <= (w_grant == PORT1) ? io_bus.p1_addr : io_bus.p0_addr;
            r_din    <= (w_grant == PORT1) ? io_bus.p1_din  : io_bus.p0_din;
          end
        end
        ST_BUSY: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_done) begin
            r_state      <= ST_IDLE;
            r_mem_cs     <= 1'b0;
            r_last_owner <= r_owner;
            r_wdog       <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_cs <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.mem_cs   = r_mem_cs;
  assign io_bus.mem_we   = r_we;
  assign io_bus.mem_addr = r_addr;
  assign io_bus.mem_din  = r_din;

  assign io_bus.p0_ack   = w_done && (r_owner == PORT0);
  assign io_bus.p1_ack   = w_done && (r_owner == PORT1);
  assign io_bus.p0_err   = w_abort && (r_owner == PORT0);
  assign io_bus.p1_err   = w_abort && (r_owner == PORT1);
  assign io_bus.p0_dout  = io_bus.p0_ack ? w_ack_dat : '0;
  assign io_bus.p1_dout  = io_bus.p1_ack ? w_ack_dat : '0;
  assign io_bus.p0_stall = io_bus.p0_cs && !io_bus.p0_ack;
  assign io_bus.p1_stall = io_bus.p1_cs && !io_bus.p1_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (bus_a) and fixed-priority instance (bus_b).
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_mis;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.RR_EN(1'b1), .TIMEOUT(15)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_a)
  );

  mem_arbiter #(.RR_EN(1'b0), .TIMEOUT(15)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has raised the request in the current (IDLE) cycle.
  task automatic txn_a(input string tag, input bit port, input logic we,
                       input logic [31:0] addr, input logic [31:0] din, input logic [31:0] rdata);
    logic        own_ack, own_err, own_stall, oth_ack, oth_err;
    logic [31:0] own_dout, oth_dout;
    #2;
    check({tag, ".idle_cs"}, 32'(bus_a.mem_cs), 32'd0);
    step();
    #2;
    own_ack = port ? bus_a.p1_ack : bus_a.p0_ack;
    check({tag, ".busy_cs"},   32'(bus_a.mem_cs), 32'd1);
    check({tag, ".busy_addr"}, bus_a.mem_addr, addr);
    check({tag, ".busy_we"},   32'(bus_a.mem_we), 32'(we));
    check({tag, ".busy_din"},  bus_a.mem_din, din);
    check({tag, ".early_ack"}, 32'(own_ack), 32'd0);
    step();
    bus_a.mem_ack  = 1'b1;
    bus_a.mem_dout = rdata;
    #2;
    own_ack   = port ? bus_a.p1_ack   : bus_a.p0_ack;
    own_err   = port ? bus_a.p1_err   : bus_a.p0_err;
    own_stall = port ? bus_a.p1_stall : bus_a.p0_stall;
    own_dout  = port ? bus_a.p1_dout  : bus_a.p0_dout;
    oth_ack   = port ? bus_a.p0_ack   : bus_a.p1_ack;
    oth_err   = port ? bus_a.p0_err   : bus_a.p1_err;
    oth_dout  = port ? bus_a.p0_dout  : bus_a.p1_dout;
    check({tag, ".ack_addr"},  bus_a.mem_addr, addr);
    check({tag, ".ack_we"},    32'(bus_a.mem_we), 32'(we));
    check({tag, ".ack_din"},   bus_a.mem_din, din);
    check({tag, ".ack"},       32'(own_ack), 32'd1);
    check({tag, ".dout"},      own_dout, we ? 32'd0 : rdata);
    check({tag, ".err"},       32'(own_err), 32'd0);
    check({tag, ".stall"},     32'(own_stall), 32'd0);
    check({tag, ".oth_ack"},   32'(oth_ack), 32'd0);
    check({tag, ".oth_err"},   32'(oth_err), 32'd0);
    check({tag, ".oth_dout"},  oth_dout, 32'd0);
    step();
    bus_a.mem_ack = 1'b0;
    if (port) bus_a.p1_cs = 1'b0;
    else      bus_a.p0_cs = 1'b0;
  endtask

  // p0 read with no mem_ack for 14 BUSY cycles; late_ack answers in the 15th.
  task automatic wdog_run(input string tag, input bit late_ack, input logic [31:0] rdata);
    bus_a.p0_cs   = 1'b1;
    bus_a.p0_we   = 1'b0;
    bus_a.p0_addr = 32'h0000_0040;
    #2;
    check({tag, ".idle_cs"}, 32'(bus_a.mem_cs), 32'd0);
    for (int k = 1; k <= 14; k++) begin
      step();
      #2;
      check({tag, ".pre_ack"}, 32'(bus_a.p0_ack), 32'd0);
    end
    step();
    if (late_ack) begin
      bus_a.mem_ack  = 1'b1;
      bus_a.mem_dout = rdata;
    end
    #2;
    check({tag, ".cs15"},   32'(bus_a.mem_cs), 32'd1);
    check({tag, ".ack15"},  32'(bus_a.p0_ack), 32'd1);
    check({tag, ".err15"},  32'(bus_a.p0_err), late_ack ? 32'd0 : 32'd1);
    check({tag, ".dout15"}, bus_a.p0_dout, late_ack ? rdata : 32'hDEAD_BEEF);
    check({tag, ".p1_ack"}, 32'(bus_a.p1_ack), 32'd0);
    check({tag, ".p1_err"}, 32'(bus_a.p1_err), 32'd0);
    step();
    bus_a.mem_ack = 1'b0;
    bus_a.p0_cs   = 1'b0;
    #2;
    check({tag, ".after_cs"},  32'(bus_a.mem_cs), 32'd0);
    check({tag, ".after_ack"}, 32'(bus_a.p0_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst_n = 1'b0;
    {bus_a.p0_cs, bus_a.p1_cs, bus_a.p0_we, bus_a.p1_we, bus_a.mem_ack} = '0;
    {bus_a.p0_addr, bus_a.p1_addr, bus_a.p0_din, bus_a.p1_din, bus_a.mem_dout} = '0;
    {bus_b.p0_cs, bus_b.p1_cs, bus_b.p0_we, bus_b.p1_we, bus_b.mem_ack} = '0;
    {bus_b.p0_addr, bus_b.p1_addr, bus_b.p0_din, bus_b.p1_din, bus_b.mem_dout} = '0;

    #2;
    check("rst.mem_cs",   32'(bus_a.mem_cs), 32'd0);
    check("rst.mem_we",   32'(bus_a.mem_we), 32'd0);
    check("rst.mem_addr", bus_a.mem_addr, 32'd0);
    check("rst.mem_din",  bus_a.mem_din, 32'd0);
    check("rst.p0_ack",   32'(bus_a.p0_ack), 32'd0);
    check("rst.p1_err",   32'(bus_a.p1_err), 32'd0);
    check("rst.p0_dout",  bus_a.p0_dout, 32'd0);
    check("rst.b_mem_cs", 32'(bus_b.mem_cs), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset: p0 first, then p1.
    bus_a.p0_cs = 1'b1; bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h0000_0100;
    bus_a.p1_cs = 1'b1; bus_a.p1_we = 1'b0; bus_a.p1_addr = 32'h0000_0200;
    #1;
    check("rr1.p1_stall", 32'(bus_a.p1_stall), 32'd1);
    #(-0);
    txn_a("rr1.p0", 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'hA0A0_0001);
    txn_a("rr1.p1", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'hB0B0_0002);

    // Single p0 read with a one-cycle memory.
    bus_a.p0_cs = 1'b1; bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h0000_0010;
    txn_a("rd0", 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678);

    // Second simultaneous round after p0 was served last: p1 first.
    bus_a.p0_cs = 1'b1; bus_a.p0_addr = 32'h0000_0104;
    bus_a.p1_cs = 1'b1; bus_a.p1_addr = 32'h0000_0204;
    txn_a("rr2.p1", 1'b1, 1'b0, 32'h0000_0204, 32'd0, 32'hC0C0_0003);
    txn_a("rr2.p0", 1'b0, 1'b0, 32'h0000_0104, 32'd0, 32'hD0D0_0004);

    // p1 write: address/data/we held through the ack cycle, read data forced to 0.
    bus_a.p1_cs = 1'b1; bus_a.p1_we = 1'b1;
    bus_a.p1_addr = 32'h0000_0020; bus_a.p1_din = 32'hCAFE_F00D;
    txn_a("wr1", 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_AAAA);
    bus_a.p1_we = 1'b0; bus_a.p1_din = 32'd0;

    wdog_run("wdog", 1'b0, 32'd0);
    wdog_run("wdog_ack", 1'b1, 32'h7777_0026);

    // mem_ack while idle must be ignored.
    bus_a.mem_ack = 1'b1; bus_a.mem_dout = 32'h9999_9999;
    #2;
    check("idle_ack.p0", 32'(bus_a.p0_ack), 32'd0);
    check("idle_ack.p1", 32'(bus_a.p1_ack), 32'd0);
    step();
    bus_a.mem_ack = 1'b0;
    #2;
    check("idle_ack.cs", 32'(bus_a.mem_cs), 32'd0);

    // Owner drops cs mid-transaction: the access still completes with an ack.
    bus_a.p1_cs = 1'b1; bus_a.p1_addr = 32'h0000_0060;
    #2;
    step();
    bus_a.p1_cs = 1'b0;
    #2;
    check("drop.cs",    32'(bus_a.mem_cs), 32'd1);
    check("drop.stall", 32'(bus_a.p1_stall), 32'd0);
    step();
    bus_a.mem_ack = 1'b1; bus_a.mem_dout = 32'h2828_2828;
    #2;
    check("drop.ack",  32'(bus_a.p1_ack), 32'd1);
    check("drop.dout", bus_a.p1_dout, 32'h2828_2828);
    step();
    bus_a.mem_ack = 1'b0;
    #2;
    check("drop.idle", 32'(bus_a.mem_cs), 32'd0);

    // Fixed priority with p0 held: p1 is never granted.
    bus_b.p0_cs = 1'b1; bus_b.p0_addr = 32'h0000_0300;
    bus_b.p1_cs = 1'b1; bus_b.p1_addr = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("fp.idle_cs", 32'(bus_b.mem_cs), 32'd0);
      step();
      #2;
      check("fp.addr", bus_b.mem_addr, 32'h0000_0300);
      step();
      bus_b.mem_ack = 1'b1; bus_b.mem_dout = 32'(i + 16);
      #2;
      check("fp.p0_ack",   32'(bus_b.p0_ack), 32'd1);
      check("fp.p0_dout",  bus_b.p0_dout, 32'(i + 16));
      check("fp.p1_ack",   32'(bus_b.p1_ack), 32'd0);
      check("fp.p1_stall", 32'(bus_b.p1_stall), 32'd1);
      step();
      bus_b.mem_ack = 1'b0;
    end
    bus_b.p0_cs = 1'b0;
    bus_b.p1_cs = 1'b0;

    // Reset in the middle of BUSY: no ack, bus drops immediately.
    bus_a.p0_cs = 1'b1; bus_a.p0_we = 1'b0; bus_a.p0_addr = 32'h0000_0080;
    #2;
    step();
    #2;
    check("rstb.busy_cs", 32'(bus_a.mem_cs), 32'd1);
    rst_n = 1'b0;
    bus_a.mem_ack = 1'b1; bus_a.mem_dout = 32'h3333_3333;
    #1;
    check("rstb.cs",   32'(bus_a.mem_cs), 32'd0);
    check("rstb.addr", bus_a.mem_addr, 32'd0);
    check("rstb.ack",  32'(bus_a.p0_ack), 32'd0);
    check("rstb.err",  32'(bus_a.p0_err), 32'd0);
    check("rstb.dout", bus_a.p0_dout, 32'd0);
    bus_a.mem_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    txn_a("rstrec", 1'b0, 1'b0, 32'h0000_0080, 32'd0, 32'h4040_4040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin grant, 0 = fixed priority (port 0 wins).
REQ-002 Parameter TIMEOUT, default 15: max BUSY cycles without mem_ack before abort; legal range 2..255.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 p0_cs, p1_cs  in  1  port request (0 = instruction fetch, 1 = data); held until matching ack.
REQ-006 p0_we, p1_we  in  1  1 = write, 0 = read.
REQ-007 p0_addr, p1_addr  in  32  byte address.
REQ-008 p0_din, p1_din  in  32  write data.
REQ-009 p0_dout, p1_dout  out  32  read data, valid in ack cycle.
REQ-010 p0_ack, p1_ack  out  1  one-cycle completion pulse.
REQ-011 p0_stall, p1_stall  out  1  = px_cs & ~px_ack.
REQ-012 p0_err, p1_err  out  1  one-cycle pulse coincident with ack on timeout abort.
REQ-013 mem_cs, mem_we  out  1  memory request/write strobe.
REQ-014 mem_addr, mem_din  out  32  memory address/write data.
REQ-015 mem_dout  in  32  memory read data, valid when mem_ack=1.
REQ-016 mem_ack  in  1  memory completion; arrives >=1 cycle after mem_cs rises.

Function
REQ-017 FSM states IDLE, BUSY; IDLE after reset.
REQ-018 IDLE: mem_cs=0; if any px_cs=1, pick winner, latch owner, we, addr, din into registers, go BUSY next edge.
REQ-019 Pick: single requester wins; both -> RR_EN=1: port not served last (last_owner reset 1, so port 0 first); RR_EN=0: port 0.
REQ-020 BUSY: mem_cs=1, mem_we/mem_addr/mem_din from latched registers, stable for whole BUSY incl. ack cycle.
REQ-021 BUSY & mem_ack: owner ack=1, owner dout=mem_dout if read else 0, last_owner<=owner, go IDLE.
REQ-022 Non-owner ack, dout, err stay 0 always.
REQ-023 Latency with idle arbiter and 1-cycle memory: request seen cycle T, mem_cs cycle T+1, px_ack cycle T+2.
REQ-024 Requester still asserting cs in cycle after its ack = new request, arbitrated in IDLE.
REQ-025 8-bit watchdog counts BUSY cycles, cleared on IDLE; at TIMEOUT without mem_ack: owner ack=1, err=1, dout=32'hDEAD_BEEF, go IDLE.
REQ-026 mem_ack in same cycle watchdog expires: normal completion, err=0.
REQ-027 mem_ack in IDLE ignored, no port ack.
REQ-028 Owner deasserting cs during BUSY (protocol violation): transaction completes, ack still pulses.
REQ-029 Other port request during BUSY: stalls, no effect on current transaction.

Reset
REQ-030 rst=0 forces immediately: state IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, all px_ack/px_err=0, px_dout=0, watchdog=0, last_owner=1.
REQ-031 Reset mid-BUSY abandons transaction silently; no ack to owner.
REQ-032 Outputs valid first edge after rst rises.

Structure
REQ-033 Shared package mem_arb_pkg: state encoding, port index constants, ERR_DATA=32'hDEAD_BEEF, TIMEOUT default.
REQ-034 Winner selection in sub-module arb_rr2 (inputs req[1:0], last_owner, rr_en; output grant index, valid); purely combinational.

Verification
REQ-035 p0 read addr 0x10, mem_dout=0x1234_5678, mem ack 1 cycle after mem_cs -> p0_ack, p0_dout=0x1234_5678 at T+2; p1 outputs 0.
REQ-036 p0 and p1 both request cycle T, RR_EN=1 -> p0 served first, p1 next; 2nd simultaneous round -> p1 first.
REQ-037 Same as 036, RR_EN=0, p0_cs held continuously -> p1 never granted while p0 requests.
REQ-038 p1 write addr 0x20 din 0xCAFE_F00D -> mem_we=1, mem_addr=0x20, mem_din=0xCAFE_F00D stable through ack; p1_dout=0.
REQ-039 mem_ack never arrives, TIMEOUT=15 -> at 15th BUSY cycle p0_ack=1, p0_err=1, p0_dout=0xDEAD_BEEF; then IDLE.
REQ-040 rst=0 during BUSY -> mem_cs drops same cycle, no ack; after release, first p0 request completes normally.
